// File: rtl/ram_fifo_pkg.sv
// Purpose : shared constants for the RAM-backed FIFO controller.
// Latency : n/a (constants only).
// Backpressure: n/a.
// Contents: default address/data widths, default depth, occupancy counter width.
package ram_fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  // Occupancy can reach DEPTH+1 (full RAM plus the output stage).
  localparam int CNT_W      = ADDR_W_DEF + 1;

  function automatic int depth_of(input int aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Purpose : wrap-around W-bit pointer with increment enable.
// Latency : pointer advances on the rising edge after inc_i.
// Backpressure: none; the owner decides when to increment.
// Ports   : clk, rst_n (async active-low), inc_i, ptr_o.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Natural overflow of the W-bit sum gives the modulo-DEPTH wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Purpose : FIFO controller driving a registered-read dual-port RAM, with a show-ahead output stage.
// Latency : push to rd_valid is 2 cycles on an empty FIFO; 1 push + 1 pop per cycle sustained.
// Backpressure: wr_ready drops when the RAM holds DEPTH unread entries; rd_ready stalls the output stage.
// Ports   : clk, rst_n; push wr_valid/wr_ready/wr_data; pop rd_valid/rd_ready/rd_data;
//           RAM ram_we/ram_wr_addr/ram_din, ram_re/ram_re_addr, ram_dout; status count/full/empty.
// Option  : RAM_FIFO_ALMOST_EN adds registered almost_full/almost_empty and their thresholds.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef RAM_FIFO_ALMOST_EN
  ,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_re_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
`ifdef RAM_FIFO_ALMOST_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic              empty
);

  localparam int CW   = ADDR_W + 1;
  localparam int DPTH = depth_of(ADDR_W);

  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic          out_vld_q, out_vld_d;
  logic          push, issue, pop;
  logic [CW-1:0] count_d;

  // Readiness depends only on RAM occupancy so there is no rd_ready -> wr_ready path.
  assign full     = (mem_cnt_q == CW'(DPTH));
  assign wr_ready = !full && rst_n;
  assign push     = wr_valid && wr_ready;
  assign pop      = out_vld_q && rd_ready;
  // Refill the output stage when it is empty or being drained this cycle.
  assign issue    = (mem_cnt_q != '0) && (!out_vld_q || rd_ready);

  always_comb begin
    mem_cnt_d = mem_cnt_q + CW'(push) - CW'(issue);
    out_vld_d = out_vld_q;
    if (issue)    out_vld_d = 1'b1;
    else if (pop) out_vld_d = 1'b0;
    count_d   = mem_cnt_d + CW'(out_vld_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

  fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push),
    .ptr_o (ram_wr_addr)
  );

  fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (issue),
    .ptr_o (ram_re_addr)
  );

  assign ram_we   = push;
  assign ram_din  = wr_data;
  assign ram_re   = issue;
  assign rd_valid = out_vld_q;
  // The RAM holds its output while ram_re is low, so it doubles as the output register.
  assign rd_data  = ram_dout;
  assign count    = mem_cnt_q + CW'(out_vld_q);
  assign empty    = (count == '0);

`ifdef RAM_FIFO_ALMOST_EN
  logic afull_q, aempty_q;

  // Registered from next-state occupancy so the flags move on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= (count_d >= CW'(AFULL_THRESH));
      aempty_q <= (count_d <= CW'(AEMPTY_THRESH));
    end
  end

  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^count_d;
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that drives the write and read ports of a 16x8 registered-read dual-port RAM. It presents valid/ready push and pop interfaces to the datapath and produces we/wr_addr/din and re/re_addr toward the RAM. It absorbs the RAM's one-cycle read latency with a show-ahead output stage. It sits between a producer block and a consumer block, with the RAM instantiated beside it at the next level up.

## Interface
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W entries
- DATA_W, 8, data width
- AFULL_THRESH, 12, almost_full asserts when count >= value (used only with RAM_FIFO_ALMOST_EN)
- AEMPTY_THRESH, 2, almost_empty asserts when count <= value (used only with RAM_FIFO_ALMOST_EN)
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  producer offers wr_data
- wr_ready  out  1  controller accepts; transfer when wr_valid && wr_ready
- wr_data  in  DATA_W  push data
- rd_valid  out  1  rd_data holds the head entry
- rd_ready  in  1  consumer takes head; transfer when rd_valid && rd_ready
- rd_data  out  DATA_W  head data, driven straight from ram_dout
- ram_we  out  1  RAM write enable
- ram_wr_addr  out  ADDR_W  RAM write address
- ram_din  out  DATA_W  RAM write data
- ram_re  out  1  RAM read enable
- ram_re_addr  out  ADDR_W  RAM read address
- ram_dout  in  DATA_W  RAM registered read data; holds while ram_re = 0
- count  out  ADDR_W+1  total occupancy (RAM entries plus output stage)
- full, empty  out  1  status flags
- almost_full, almost_empty  out  1  present only with RAM_FIFO_ALMOST_EN

## Operation
- State: wr_ptr, rd_ptr (ADDR_W bits, wrap modulo DEPTH), mem_count (0..DEPTH), out_valid.
- Reset values: wr_ptr = rd_ptr = 0, mem_count = 0, out_valid = 0. Outputs: wr_ready = 0 while rst_n is low, then 1; rd_valid = 0; ram_we = ram_re = 0; count = 0; full = 0; empty = 1. rd_data is undefined and is qualified by rd_valid.
- Push: wr_ready = !full && rst_n. ram_we = wr_valid && wr_ready. ram_wr_addr = wr_ptr. ram_din = wr_data. wr_ptr increments on a push.
- Read issue: ram_re = (mem_count != 0) && (!out_valid || rd_ready). ram_re_addr = rd_ptr. rd_ptr increments on issue.
- Output stage: out_valid is set on the next edge after ram_re. It clears on a pop with no read issued in the same cycle. rd_valid = out_valid.
- mem_count next = mem_count + push - issue. count = mem_count + out_valid. Maximum count = DEPTH+1.
- full = (mem_count == DEPTH). empty = (count == 0).
- Simultaneous push and issue: both take effect and mem_count is unchanged. An issue only targets entries written in an earlier cycle, so there is no same-address read/write hazard.
- wr_ready has no combinational dependence on rd_ready. A push while full is refused even if a pop happens in the same cycle.
- Pointer wrap from 15 to 0 is seamless. full and empty are derived from the counts, never from pointer compare.
- Reset asserted mid-operation: all entries are discarded immediately and the block returns to its reset values. RAM contents are left untouched.

## Timing
- Push-to-rd_valid latency on an empty FIFO is 2 cycles: push at edge N, ram_re during cycle N+1, rd_valid at N+2.
- Sustained throughput is 1 push and 1 pop per cycle. Back-to-back pops need no bubble once mem_count > 0.
- full rises one cycle after the DEPTH-th unread RAM write. wr_ready falls in the same cycle full rises.

## Configuration
- RAM_FIFO_ALMOST_EN defined: almost_full = (count >= AFULL_THRESH) and almost_empty = (count <= AEMPTY_THRESH). Both are registered from next-state count, so they change on the same edge as count. Both reset to almost_full = 0, almost_empty = 1.
- RAM_FIFO_ALMOST_EN undefined: the ports, thresholds logic and registers are absent.

## Structure
- Shared package ram_fifo_pkg: ADDR_W/DATA_W defaults, DEPTH, and the count width constant.
- One sub-module, fifo_ptr: a wrap-around ADDR_W pointer with increment enable and async active-low reset. It is instantiated twice, for wr_ptr and rd_ptr.

## Test plan
- Reset, then one push of 0xA5 with rd_ready = 1 -> ram_we for 1 cycle at addr 0, ram_re at addr 0 next cycle, rd_valid with rd_data = 0xA5 two cycles after push, empty = 1 after the pop.
- Push 16 values 0x00..0x0F with rd_ready = 0 -> output stage loads 0x00, count reaches 16, full stays 0; push 0x10 -> full = 1, wr_ready = 0, count = 17; further pushes are refused.
- From full, pop and push every cycle for 40 cycles -> data emerges in order with no loss; pointers wrap past 15; count stays 16 or 17.
- Push and pop continuously across wrap for 100 random values -> output sequence equals input sequence; rd_valid has no gaps after the first.
- Assert rst_n low mid-stream with count = 9 -> count = 0, empty = 1, rd_valid = 0 and wr_ready = 0 while low; the first push after release reads back correctly from addr 0.
- With RAM_FIFO_ALMOST_EN: fill to 12 -> almost_full rises on the 12th push edge; drain to 2 -> almost_empty rises.
